inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction sequencer directly upstream of the lab CPU control FSM.
- Holds a small programmable instruction memory and a program counter.
- Presents one 16-bit instruction on d_inst and drives run through the controller's three-cycle S0/S1/S2 sequence.
- Advances on the controller's done pulse and stops on a HALT word or at the end of memory.

Parameters:
- DEPTH, 16, number of instruction words (power of two, 2..256).
- AW, $clog2(DEPTH), address / PC width.
- HALT_WORD, 16'hFFFF, encoding that terminates the program.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  AW  write address.
- prog_data  in  16  write data.
- start  in  1  begin execution from PC 0 (level, sampled per cycle).
- done  in  1  controller end-of-instruction flag (high in its S2 while run=1).
- d_inst  out  16  current instruction to controller.
- run  out  1  execute request to controller.
- pc  out  AW  current program counter.
- busy  out  1  executing (FETCH/CHECK/RUN).
- halted  out  1  program finished.
- retired  out  8  instructions completed, saturating at 255.

Behaviour:
- Reset (async): state=IDLE, pc=0, d_inst=0, run=0, busy=0, halted=0, retired=0. Memory contents are not reset.
- Memory writes:
  - A write occurs on a clk edge only when prog_we=1 and the state is IDLE or HALT.
  - prog_we is ignored in any other state; there is no error flag.
- States: IDLE, FETCH, CHECK, RUN, HALT.
- IDLE: start=1 → FETCH with pc=0 and retired=0.
- FETCH (1 cycle): d_inst <= mem[pc]; → CHECK.
- CHECK (1 cycle): d_inst==HALT_WORD → HALT; otherwise → RUN. run=0 in this state.
- RUN:
  - run=1 combinationally, and d_inst is held stable.
  - On a cycle with done=1:
    - run drops to 0 in the next cycle.
    - retired increments (saturating).
    - If pc==DEPTH-1 → HALT with pc unchanged; else pc<=pc+1 → FETCH.
  - The controller therefore sees exactly three run-high cycles per instruction (S0, S1, S2) and returns to S0 with run=0, where it stalls.
- Throughput: 5 cycles per instruction (FETCH, CHECK, three RUN cycles).
- HALT:
  - halted=1, run=0, d_inst keeps its last value.
  - start=1 → FETCH with pc=0 and retired=0, halted cleared.
- busy=1 exactly in FETCH, CHECK and RUN.
- start is ignored in FETCH, CHECK and RUN.
- done outside RUN is ignored.
- done is sampled only while run=1; done asserted on the first RUN cycle is honoured (no minimum dwell).
- Reset mid-RUN: run falls asynchronously and the state returns to IDLE. The controller is reset by the same signal.
- prog_we and start in the same IDLE cycle: the write completes and execution starts. The FETCH of that address in the next cycle sees the new data.

Optional Feature:
- Macro: INST_FETCH_SINGLE_STEP_EN.
- With the macro:
  - Extra ports: step_mode (in, 1) and step (in, 1).
  - When step_mode=1, completing RUN enters PAUSE instead of FETCH.
  - PAUSE holds pc+1 and run=0, and leaves to FETCH on a cycle with step=1.
  - A HALT transition takes priority over PAUSE.
  - busy=1 in PAUSE.
- Without the macro: no extra ports, no PAUSE state, behaviour as above.

Decomposition:
- Package inst_fetch_pkg:
  - state enum (IDLE, FETCH, CHECK, RUN, HALT, PAUSE).
  - HALT_WORD default.
  - Instruction field constants: DST [15:13], SRC [12:10], SEL [6:3], MODE [2].
- One sub-module, inst_mem:
  - DEPTH×16 array.
  - Synchronous write port; registered read port used by FETCH.

Test Plan:
- Reset, write mem[0]=16'h2458 and mem[1]=16'hFFFF, pulse start. Response:
  - run high for exactly 3 cycles while d_inst=16'h2458.
  - Then HALT, with halted=1, pc=1, retired=1.
- Fill all 16 words with 16'h0004, start. Response:
  - 16 instructions of 5 cycles each.
  - Then HALT at pc=15, retired=16; the last run falls after done.
- Assert reset during the 2nd RUN cycle. Response:
  - run=0 immediately (async), pc=0, state IDLE.
  - A subsequent start re-executes from word 0.
- prog_we=1, addr=3, data=16'hABCD while busy. Response: mem[3] is unchanged when read back after HALT.
- From HALT, assert start again. Response: halted drops next cycle, pc=0, retired=0, first fetch of mem[0].
- With INST_FETCH_SINGLE_STEP_EN and step_mode=1, run a 3-word program. Response:
  - After each done, run=0 and the fetcher waits in PAUSE until a step pulse.
  - Then the next instruction is issued with pc incremented.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared states, halt encoding and instruction field positions for inst_fetch
package inst_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4,
    ST_PAUSE = 3'd5
  } state_e;

  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  localparam int DST_MSB  = 15;
  localparam int DST_LSB  = 13;
  localparam int SRC_MSB  = 12;
  localparam int SRC_LSB  = 10;
  localparam int SEL_MSB  = 6;
  localparam int SEL_LSB  = 3;
  localparam int MODE_BIT = 2;

  function automatic logic [2:0] inst_dst(input logic [15:0] inst);
    return inst[DST_MSB:DST_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - programming, start/done handshake and status bundle between fetcher and its environment
interface inst_fetch_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic          done;
  logic [15:0]   d_inst;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [7:0]    retired;

  modport master (
    output prog_we, prog_addr, prog_data, start, done,
    input  d_inst, run, pc, busy, halted, retired
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, done,
    output d_inst, run, pc, busy, halted, retired
  );
endinterface

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - DEPTHx16 program store, synchronous write, registered read held between fetches
module inst_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  logic [15:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the instruction latch, so it only loads on a fetch.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction sequencer feeding the S0/S1/S2 controller; INST_FETCH_SINGLE_STEP_EN adds step_mode/step and PAUSE
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic       clk,
  input  logic       reset,
`ifdef INST_FETCH_SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  inst_fetch_if.slave bus
);
  state_e        state_d, state_q;
  logic [AW-1:0] pc_d, pc_q;
  logic [7:0]    retired_d, retired_q;
  logic          mem_we;
  logic [15:0]   mem_rdata;

  inst_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .re    (state_q == ST_FETCH),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    mem_we    = bus.prog_we && (state_q == ST_IDLE || state_q == ST_HALT);
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: state_d = (mem_rdata == HALT_WORD) ? ST_HALT : ST_RUN;
      ST_RUN: begin
        if (bus.done) begin
          retired_d = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
          if (pc_q == AW'(DEPTH - 1)) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
`ifdef INST_FETCH_SINGLE_STEP_EN
            state_d = step_mode ? ST_PAUSE : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
`ifdef INST_FETCH_SINGLE_STEP_EN
      ST_PAUSE: if (step) state_d = ST_FETCH;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // run is decoded straight from the state flop so reset drops it without waiting for a clock.
  assign bus.run     = (state_q == ST_RUN);
  assign bus.busy    = (state_q == ST_FETCH) || (state_q == ST_CHECK) ||
                       (state_q == ST_RUN)   || (state_q == ST_PAUSE);
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.d_inst  = mem_rdata;
  assign bus.pc      = pc_q;
  assign bus.retired = retired_q;
endmodule
